// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared types and constants for the operator numeric-input port.
//            FSM state encoding, BCD digit width, accumulator width and the
//            saturation limit of the binary result, plus the x10+digit step
//            used by the sequential BCD-to-binary conversion.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int BCD_W     = 4;
   localparam int ACC_W     = 10;
   localparam int MAX_VALUE = 255;

   localparam logic [BCD_W-1:0] MAX_DIGIT = 4'd9;

   // One Horner step: acc*10 + digit, built from shifts.
   function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] acc,
                                                 input logic [BCD_W-1:0] digit);
      return (acc << 3) + (acc << 1) + ACC_W'(digit);
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Synchronises and debounces one active-low push key and emits a
//            one-cycle press pulse on each accepted 1->0 transition.
// Ports    : clock  - system clock
//            resetn - asynchronous active-low reset
//            key_n  - raw, bouncy, asynchronous key (active-low)
//            level  - accepted (debounced) key level, 1 = released
//            press  - one-cycle pulse when the accepted level falls
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic clock,
   input  logic resetn,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   // Synchroniser idles high so a released key produces no event out of reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= key_n;
         r_sync2 <= r_sync1;
      end
   end

   // The counter only runs while the synced level disagrees with the accepted
   // level, so any bounce back to the accepted level restarts the window.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == C_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
            r_press <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/digit_entry.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry
// Purpose  : Operator numeric input. ENTER shifts a BCD switch digit into a
//            three-digit entry register and starts a 3-cycle BCD-to-binary
//            conversion; the saturated 8-bit result is offered to the CPU
//            through a valid/read handshake. CLEAR resets the entry.
// Ports    : clock, resetn         - clock, asynchronous active-low reset
//            sw[3:0]               - BCD digit from the slide switches
//            key_enter_n           - raw ENTER key (active-low)
//            key_clear_n           - raw CLEAR key (active-low)
//            value_read            - CPU read pulse, consumes the result
//            value[7:0]            - converted (saturated) binary value
//            value_valid           - value holds an unread result
//            overflow              - last conversion exceeded 255
//            bcd[11:0]             - entry register {hundreds, tens, ones}
// Revision : 1.0 - initial release
// ============================================================================
module digit_entry
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [3:0]  sw,
   input  logic        key_enter_n,
   input  logic        key_clear_n,
   input  logic        value_read,
   output logic [7:0]  value,
   output logic        value_valid,
   output logic        overflow,
   output logic [11:0] bcd
);

   logic             w_enter_level;
   logic             w_clear_level;
   logic             w_enter_press;
   logic             w_clear_press;
   logic [1:0]       w_unused_levels;

   state_t           r_state;
   state_t           w_next_state;
   logic             w_start;
   logic             w_in_conv;
   logic             w_in_done;

   logic [11:0]      r_bcd;
   logic [ACC_W-1:0] r_acc;
   logic [1:0]       r_idx;
   logic [7:0]       r_value;
   logic             r_valid;
   logic             r_overflow;
   logic [BCD_W-1:0] w_digit;
   logic             w_enter_ok;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_enter (
      .clock  (clock),
      .resetn (resetn),
      .key_n  (key_enter_n),
      .level  (w_enter_level),
      .press  (w_enter_press)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_clear (
      .clock  (clock),
      .resetn (resetn),
      .key_n  (key_clear_n),
      .level  (w_clear_level),
      .press  (w_clear_press)
   );

   // Only the press pulses drive behaviour; the levels are kept for debug.
   assign w_unused_levels = {w_enter_level, w_clear_level};

   // CLEAR wins over a simultaneous ENTER. The switches are only sampled on
   // an ENTER event, long after the operator has set them, so no sync stage.
   assign w_enter_ok = w_enter_press & ~w_clear_press & (sw <= MAX_DIGIT);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_enter_ok) w_next_state = CONV;
         CONV:    if (r_idx == 2'd2) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
      if (w_clear_press) w_next_state = IDLE;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_start   = 1'b0;
      w_in_conv = 1'b0;
      w_in_done = 1'b0;
      case (r_state)
         IDLE:    w_start   = w_enter_ok;
         CONV:    w_in_conv = 1'b1;
         DONE:    w_in_done = 1'b1;
         default: ;
      endcase
   end

   // Hundreds first, so the Horner step builds the value left to right.
   always_comb begin
      case (r_idx)
         2'd0:    w_digit = r_bcd[11:8];
         2'd1:    w_digit = r_bcd[7:4];
         default: w_digit = r_bcd[3:0];
      endcase
   end

   // ---------------- Datapath and handshake ----------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_bcd      <= '0;
         r_acc      <= '0;
         r_idx      <= '0;
         r_value    <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_clear_press) begin
         r_bcd      <= '0;
         r_acc      <= '0;
         r_idx      <= '0;
         r_value    <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_start) begin
            r_bcd <= {r_bcd[7:0], sw};
            r_acc <= '0;
            r_idx <= '0;
         end
         if (w_in_conv) begin
            r_acc <= acc_step(r_acc, w_digit);
            r_idx <= r_idx + 2'd1;
         end
         // A fresh result takes priority over a same-cycle read so it is
         // never silently marked as consumed.
         if (w_in_done) begin
            r_valid <= 1'b1;
            if (r_acc > ACC_W'(MAX_VALUE)) begin
               r_value    <= 8'(MAX_VALUE);
               r_overflow <= 1'b1;
            end else begin
               r_value    <= r_acc[7:0];
               r_overflow <= 1'b0;
            end
         end else if (value_read) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign value       = r_value;
   assign value_valid = r_valid;
   assign overflow    = r_overflow;
   assign bcd         = r_bcd;

endmodule
`default_nettype wire

// File: doc/digit_entry.md
# digit_entry

Operator numeric-input port for the pipelined computer's I/O space: the input-side counterpart of the three-digit decimal display. It debounces two push keys, shifts a BCD digit from the switches into a three-digit entry register on each ENTER press, and converts the entry to an 8-bit binary value sequentially. The result is presented to the CPU's I/O read port through a valid/read handshake. The BCD entry is also echoed back so the display path can show the digits as they are typed.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz).
- CNT_W, 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- clock  in  1  single system clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- sw  in  4  BCD digit from slide switches; asynchronous, sampled only on an ENTER event.
- key_enter_n  in  1  raw ENTER push key, active-low, asynchronous, bouncy.
- key_clear_n  in  1  raw CLEAR push key, active-low, asynchronous, bouncy.
- value_read  in  1  one-cycle pulse from the CPU I/O read that consumes the value.
- value  out  8  converted binary value.
- value_valid  out  1  value holds an unread result.
- overflow  out  1  last conversion exceeded 255; value saturated.
- bcd  out  12  entry register {hundreds, tens, ones}, to the display path.

## Operation
- Key conditioning, per key:
  - 2-flop synchronizer feeds a debounce counter.
  - If the synced level differs from the accepted level, the counter increments. Otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level takes the synced level and the counter clears.
  - An event is a one-cycle pulse on an accepted 1->0 transition. Release generates no event.
- ENTER event with sw <= 9: bcd <= {bcd[7:0], sw}, and the FSM goes IDLE -> CONV.
- ENTER event with sw > 9: no effect.
- ENTER event while not in IDLE: ignored.
- FSM states IDLE, CONV, DONE:
  - CONV runs 3 cycles on a 10-bit accumulator: acc <= (acc<<3) + (acc<<1) + digit.
  - Digits are consumed hundreds, then tens, then ones; acc clears on entry to CONV.
  - DONE lasts 1 cycle, then returns to IDLE.
  - In DONE: if acc > 255, value <= 255 and overflow <= 1; else value <= acc[7:0] and overflow <= 0. In both cases value_valid <= 1.
- Handshake:
  - value_read while value_valid=1 clears value_valid. value and overflow hold.
  - value_read while value_valid=0 has no effect.
  - DONE and value_read in the same cycle: value_valid stays 1, and the new value is loaded.
  - A new result while value_valid=1 overwrites value; value_valid stays 1.
- CLEAR event: bcd, value, overflow, value_valid and acc clear; the FSM goes to IDLE, aborting any conversion.
  - CLEAR and ENTER events in the same cycle: CLEAR wins and the ENTER is dropped.
- Four or more ENTERs keep the latest three digits; the oldest is shifted out.

## Timing
- Reset values:
  - value=0, value_valid=0, overflow=0, bcd=0, state IDLE, acc=0.
  - Accepted key levels=1 (released); counters=0; synchronizer flops=1.
- Key latency: a clean press reaches its event pulse 2 (sync) + DEBOUNCE_CYCLES cycles after the raw edge.
- Event at cycle E:
  - bcd is updated after edge E.
  - CONV occupies cycles E+1..E+3 and DONE occupies E+4.
  - value and value_valid are visible from E+5, i.e. 5 cycles after the event pulse.
- Mid-operation resetn assertion forces all reset values immediately (asynchronous). Deassertion is used synchronously by the design.

## Structure
- Shared package io_pkg:
  - FSM state encodings (IDLE=2'd0, CONV=2'd1, DONE=2'd2).
  - BCD digit width 4, MAX_VALUE 255, ACC_W 10.
- Sub-module key_debounce (parameters DEBOUNCE_CYCLES, CNT_W):
  - Ports: clock, resetn, key_n, level, press.
  - Instantiated twice, once per key.
- Top: entry shift register, accumulator FSM, output/handshake registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset with keys released -> all outputs 0, bcd=12'h000, no event generated.
- ENTER bouncing 1-0-1-0 for 3 cycles then held low with sw=4'd7 -> exactly one event; bcd=12'h007; value=8'd7 and value_valid=1 five cycles after the event.
- ENTER digits 2, 5, 5 -> bcd=12'h255, value=8'd255, overflow=0. Then ENTER digit 6 -> bcd=12'h556, value=8'd255, overflow=1, value_valid still 1.
- ENTER with sw=4'hC -> bcd, value and value_valid unchanged; the FSM never leaves IDLE.
- value_read pulse while valid -> value_valid=0 and value holds. value_read in the same cycle as DONE -> value_valid=1 with the new value.
- CLEAR event during CONV -> bcd=0, value=0, value_valid=0, state IDLE, no DONE. resetn pulse mid-CONV -> all outputs 0 the same cycle.
